// File: rtl/huffman_code_gen.sv
// Huffman code generator: captures the five merge records of a 6-leaf tree, then walks it from root 6.
// Define HC_LEFT_ALIGN_EN to emit MSB-aligned codes and masks instead of right-aligned ones.
module huffman_code_gen #(
  parameter int CODE_W = 8,
  parameter int N_SYM  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        node_l,
  input  logic [3:0]        node_r,
  input  logic [3:0]        root_sel,
  input  logic              w_r,
  input  logic              cmb_cmp_flg,
  output logic [CODE_W-1:0] HC1,
  output logic [CODE_W-1:0] HC2,
  output logic [CODE_W-1:0] HC3,
  output logic [CODE_W-1:0] HC4,
  output logic [CODE_W-1:0] HC5,
  output logic [CODE_W-1:0] HC6,
  output logic [CODE_W-1:0] M1,
  output logic [CODE_W-1:0] M2,
  output logic [CODE_W-1:0] M3,
  output logic [CODE_W-1:0] M4,
  output logic [CODE_W-1:0] M5,
  output logic [CODE_W-1:0] M6,
  output logic              code_valid,
  output logic              err,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, ASSIGN, DONE} state_t;

  state_t            state;
  logic [7:0]        tbl [0:4];
  logic [2:0]        cnt, k;
  logic [CODE_W-1:0] pre [0:4];
  logic [2:0]        len [0:4];
  logic [CODE_W-1:0] hc  [0:N_SYM-1];
  logic [CODE_W-1:0] m   [0:N_SYM-1];

  logic              rec_ok;
  logic [2:0]        cnt_nx, root_idx, l_idx, r_idx, len_c;
  logic [3:0]        child_l, child_r;
  logic [CODE_W-1:0] code_l, code_r, hc_lv, hc_rv, m_v;

  always_comb begin
    rec_ok   = w_r && root_sel >= 4'd6 && root_sel <= 4'd10 && cnt != 3'd5;
    cnt_nx   = cnt + {2'b00, rec_ok};
    root_idx = 3'(root_sel - 4'd6);
    child_l  = tbl[k][7:4];
    child_r  = tbl[k][3:0];
    l_idx    = 3'(child_l - 4'd6);
    r_idx    = 3'(child_r - 4'd6);
    code_l   = (pre[k] << 1) | CODE_W'(1);
    code_r   = pre[k] << 1;
    len_c    = len[k] + 3'd1;
  end

  // Leaf write-back formatting; the walk itself never depends on alignment.
  always_comb begin
`ifdef HC_LEFT_ALIGN_EN
    int sh;
    sh    = CODE_W - int'(len_c);
    hc_lv = code_l << sh;
    hc_rv = code_r << sh;
    m_v   = ~((CODE_W'(1) << sh) - CODE_W'(1));
`else
    hc_lv = code_l;
    hc_rv = code_r;
    m_v   = (CODE_W'(1) << len_c) - CODE_W'(1);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      k          <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      code_valid <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        tbl[i] <= '0;
        pre[i] <= '0;
        len[i] <= '0;
      end
      for (int i = 0; i < N_SYM; i++) begin
        hc[i] <= '0;
        m[i]  <= '0;
      end
    end else begin
      code_valid <= 1'b0;
      if (start) begin
        state <= COLLECT;
        busy  <= 1'b1;
        cnt   <= '0;
        err   <= 1'b0;
        for (int i = 0; i < 5; i++) tbl[i] <= '0;
        for (int i = 0; i < N_SYM; i++) begin
          hc[i] <= '0;
          m[i]  <= '0;
        end
      end else begin
        case (state)
          IDLE: ;
          COLLECT: begin
            if (rec_ok) begin
              tbl[root_idx] <= {node_l, node_r};
              cnt           <= cnt_nx;
            end
            if (w_r && !rec_ok) err <= 1'b1;
            // Count check includes a record landing in the same cycle as the done flag.
            if (cmb_cmp_flg) begin
              if (cnt_nx == 3'd5) begin
                state  <= ASSIGN;
                k      <= '0;
                pre[0] <= '0;
                len[0] <= '0;
              end else begin
                err   <= 1'b1;
                state <= DONE;
                busy  <= 1'b0;
              end
            end
          end
          ASSIGN: begin
            if (child_l < 4'd6) begin
              hc[child_l[2:0]] <= hc_lv;
              m[child_l[2:0]]  <= m_v;
            end else if (child_l <= 4'd10) begin
              pre[l_idx] <= code_l;
              len[l_idx] <= len_c;
            end
            if (child_r < 4'd6) begin
              hc[child_r[2:0]] <= hc_rv;
              m[child_r[2:0]]  <= m_v;
            end else if (child_r <= 4'd10) begin
              pre[r_idx] <= code_r;
              len[r_idx] <= len_c;
            end
            k <= k + 3'd1;
            if (k == 3'd4) begin
              state <= DONE;
              busy  <= 1'b0;
            end
          end
          DONE: begin
            code_valid <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign HC1 = hc[0];
  assign HC2 = hc[1];
  assign HC3 = hc[2];
  assign HC4 = hc[3];
  assign HC5 = hc[4];
  assign HC6 = hc[5];
  assign M1  = m[0];
  assign M2  = m[1];
  assign M3  = m[2];
  assign M4  = m[3];
  assign M5  = m[4];
  assign M6  = m[5];
endmodule

// File: tb/tb_huffman_code_gen.sv
// Directed bench for huffman_code_gen: balanced/chain trees, malformed jobs, abort and mid-job reset.
module tb_huffman_code_gen;
  logic       clk = 1'b0;
  logic       reset, start, w_r, cmb_cmp_flg;
  logic [3:0] node_l, node_r, root_sel;
  logic [7:0] HC1, HC2, HC3, HC4, HC5, HC6, M1, M2, M3, M4, M5, M6;
  logic       code_valid, err, busy;
  int         n_chk = 0;
  int         n_fail = 0;

  // Packed per symbol: symbol i lives in bits [8*i +: 8].
`ifdef HC_LEFT_ALIGN_EN
  localparam logic [47:0] BAL_HC = 48'hE0C060408000;
  localparam logic [47:0] BAL_M  = 48'hE0E0E0E0C0C0;
  localparam logic [47:0] CHN_HC = 48'hF8F0E0C08000;
  localparam logic [47:0] CHN_M  = 48'hF8F8F0E0C080;
  localparam logic [47:0] BAL_M1 = 48'h0000000000C0;
`else
  localparam logic [47:0] BAL_HC = 48'h070603020200;
  localparam logic [47:0] BAL_M  = 48'h070707070303;
  localparam logic [47:0] CHN_HC = 48'h1F1E0E060200;
  localparam logic [47:0] CHN_M  = 48'h1F1F0F070301;
  localparam logic [47:0] BAL_M1 = 48'h000000000003;
`endif

  logic [47:0] hc_all, m_all;
  assign hc_all = {HC6, HC5, HC4, HC3, HC2, HC1};
  assign m_all  = {M6, M5, M4, M3, M2, M1};

  huffman_code_gen #(.CODE_W(8), .N_SYM(6)) dut (
    .clk(clk), .reset(reset), .start(start), .node_l(node_l), .node_r(node_r),
    .root_sel(root_sel), .w_r(w_r), .cmb_cmp_flg(cmb_cmp_flg),
    .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
    .code_valid(code_valid), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic merge(input logic [3:0] l, input logic [3:0] r, input logic [3:0] root,
                       input logic flg = 1'b0);
    w_r = 1'b1; node_l = l; node_r = r; root_sel = root; cmb_cmp_flg = flg;
    step();
    w_r = 1'b0; cmb_cmp_flg = 1'b0;
  endtask

  task automatic begin_job();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_flag();
    cmb_cmp_flg = 1'b1;
    step();
    cmb_cmp_flg = 1'b0;
  endtask

  task automatic balanced_merges();
    merge(4'd5, 4'd4, 4'd10);
    merge(4'd3, 4'd2, 4'd9);
    merge(4'd10, 4'd1, 4'd8);
    merge(4'd9, 4'd0, 4'd7);
    merge(4'd8, 4'd7, 4'd6);
  endtask

  // Called just after the edge that sampled cmb_cmp_flg; counts edges until code_valid.
  task automatic wait_valid(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (code_valid) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 48'(lat), 48'(exp_lat));
    step();
    check({tag, "_pulse_end"}, {47'b0, code_valid}, 48'h0);
    check({tag, "_busy_idle"}, {47'b0, busy}, 48'h0);
  endtask

  initial begin
    int pulses;
    reset = 1'b1; start = 1'b0; w_r = 1'b0; cmb_cmp_flg = 1'b0;
    node_l = '0; node_r = '0; root_sel = '0;
    step(); step();
    reset = 1'b0;
    check("reset_hc", hc_all, 48'h0);
    check("reset_m", m_all, 48'h0);
    check("reset_flags", {45'b0, code_valid, err, busy}, 48'h0);

    // Balanced tree
    begin_job();
    check("bal_busy_collect", {47'b0, busy}, 48'h1);
    balanced_merges();
    finish_flag();
    wait_valid("bal", 6);
    check("bal_hc", hc_all, BAL_HC);
    check("bal_m", m_all, BAL_M);
    check("bal_err", {47'b0, err}, 48'h0);

    // Chain tree, final record arrives with the done flag
    begin_job();
    merge(4'd5, 4'd4, 4'd10);
    merge(4'd10, 4'd3, 4'd9);
    merge(4'd9, 4'd2, 4'd8);
    merge(4'd8, 4'd1, 4'd7);
    merge(4'd7, 4'd0, 4'd6, 1'b1);
    wait_valid("chain", 6);
    check("chain_hc", hc_all, CHN_HC);
    check("chain_m", m_all, CHN_M);
    check("chain_err", {47'b0, err}, 48'h0);

    // Short job: four merges only
    begin_job();
    check("short_cleared", hc_all | m_all, 48'h0);
    merge(4'd5, 4'd4, 4'd10);
    merge(4'd3, 4'd2, 4'd9);
    merge(4'd10, 4'd1, 4'd8);
    merge(4'd9, 4'd0, 4'd7);
    finish_flag();
    wait_valid("short", 1);
    check("short_err", {47'b0, err}, 48'h1);
    check("short_hc", hc_all, 48'h0);
    check("short_m", m_all, 48'h0);

    // Overflow: a sixth record must be ignored
    begin_job();
    check("ovf_err_cleared", {47'b0, err}, 48'h0);
    balanced_merges();
    merge(4'd0, 4'd1, 4'd6);
    finish_flag();
    wait_valid("ovf", 6);
    check("ovf_err", {47'b0, err}, 48'h1);
    check("ovf_hc", hc_all, BAL_HC);
    check("ovf_m", m_all, BAL_M);

    // Out-of-range root id is ignored but flagged
    begin_job();
    merge(4'd0, 4'd1, 4'd12);
    balanced_merges();
    finish_flag();
    wait_valid("badroot", 6);
    check("badroot_err", {47'b0, err}, 48'h1);
    check("badroot_hc", hc_all, BAL_HC);
    check("badroot_m", m_all, BAL_M);

    // Abort on the third ASSIGN cycle
    begin_job();
    balanced_merges();
    finish_flag();
    step(); step();
    check("abort_partial_m1", {40'b0, M1}, BAL_M1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("abort_hc", hc_all, 48'h0);
    check("abort_m", m_all, 48'h0);
    check("abort_busy", {47'b0, busy}, 48'h1);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      pulses += int'(code_valid);
    end
    check("abort_no_valid", 48'(pulses), 48'h0);
    merge(4'd5, 4'd4, 4'd10);
    merge(4'd10, 4'd3, 4'd9);
    merge(4'd9, 4'd2, 4'd8);
    merge(4'd8, 4'd1, 4'd7);
    merge(4'd7, 4'd0, 4'd6);
    finish_flag();
    wait_valid("post_abort", 6);
    check("post_abort_hc", hc_all, CHN_HC);
    check("post_abort_m", m_all, CHN_M);

    // Reset in the middle of COLLECT
    begin_job();
    merge(4'd5, 4'd4, 4'd10);
    merge(4'd3, 4'd2, 4'd9);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_reset_hc", hc_all, 48'h0);
    check("mid_reset_m", m_all, 48'h0);
    check("mid_reset_flags", {45'b0, code_valid, err, busy}, 48'h0);
    cmb_cmp_flg = 1'b1;
    step();
    cmb_cmp_flg = 1'b0;
    step();
    check("idle_ignores_flag", {46'b0, code_valid, busy}, 48'h0);
    begin_job();
    balanced_merges();
    finish_flag();
    wait_valid("post_reset", 6);
    check("post_reset_hc", hc_all, BAL_HC);
    check("post_reset_m", m_all, BAL_M);
    check("post_reset_err", {47'b0, err}, 48'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
